adc_test_pattern_gen: RTL and testbench

//  Sample-clock-domain data source for the simulated AD9643 output path.

---
 rtl/adc_test_pattern_gen_if.sv | 30 +++
 rtl/adc_test_pattern_gen.sv | 206 ++++++++++++++++++++
 tb/tb_adc_test_pattern_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/adc_test_pattern_gen_if.sv
// Sample-domain interface between the register/ADC source and the test
// pattern generator: strobe, live data, register fields and generated word.
interface adc_test_pattern_gen_if #(
  parameter int DATA_WIDTH = 14
);
  logic                  sample_en;
  logic [DATA_WIDTH-1:0] adc_data;
  logic [7:0]            test_mode;
  logic [15:0]           UserTestPattern1;
  logic [15:0]           UserTestPattern2;
  logic [15:0]           UserTestPattern3;
  logic [15:0]           UserTestPattern4;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  pattern_active;

  // Source side: drives strobe, samples and register fields.
  modport master (
    output sample_en, adc_data, test_mode,
    output UserTestPattern1, UserTestPattern2, UserTestPattern3, UserTestPattern4,
    input  data_out, data_valid, pattern_active
  );

  // Generator side.
  modport slave (
    input  sample_en, adc_data, test_mode,
    input  UserTestPattern1, UserTestPattern2, UserTestPattern3, UserTestPattern4,
    output data_out, data_valid, pattern_active
  );
endinterface

// File: rtl/adc_test_pattern_gen.sv
// AD9643-style output data source: live ADC samples or a selected test
// pattern (fixed levels, checkerboard, toggle, PN9/PN23, user words, ramp),
// one registered word per sample_en strobe.
module adc_test_pattern_gen #(
  parameter int          DATA_WIDTH = 14,
  parameter logic [8:0]  PN_SEED9   = 9'h1FF,
  parameter logic [22:0] PN_SEED23  = 23'h7FFFFF
) (
  input  logic                 clk,
  input  logic                 resetn,
  adc_test_pattern_gen_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [3:0] {
    MODE_NORMAL   = 4'h0,
    MODE_MIDSCALE = 4'h1,
    MODE_POS_FS   = 4'h2,
    MODE_NEG_FS   = 4'h3,
    MODE_CHECKER  = 4'h4,
    MODE_PN23     = 4'h5,
    MODE_PN9      = 4'h6,
    MODE_TOGGLE   = 4'h7,
    MODE_USER     = 4'h8,
    MODE_RAMP     = 4'hF
  } mode_e;

  typedef enum logic [1:0] {
    SEQ_REPEAT1 = 2'b00,
    SEQ_CYCLE4  = 2'b01,
    SEQ_SINGLE  = 2'b10,
    SEQ_ALT12   = 2'b11
  } seq_e;

  // Checkerboard word starting with a 1 in the MSB: 1010..
  function automatic logic [W-1:0] checker_word();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = ((i % 2) == ((W - 1) % 2));
    return v;
  endfunction

  localparam logic [W-1:0] CHECKER_A = checker_word();
  localparam logic [W-1:0] MIDSCALE  = {1'b1, {(W-1){1'b0}}};

  logic [7:0]   r_mode_meta, r_mode_sync;
  logic [3:0]   r_mode_prev;
  logic [1:0]   r_seq_prev;
  logic [W-1:0] r_upat [4];
  logic [W-1:0] r_ramp;
  logic [1:0]   r_uidx;
  logic         r_phase, r_single_done;
  logic [8:0]   r_pn9;
  logic [22:0]  r_pn23;
  logic [W-1:0] r_data_out;
  logic         r_data_valid;

  mode_e        w_mode;
  seq_e         w_seq;
  logic         w_mode_change, w_seq_change, w_pn9_hold, w_pn23_hold;
  logic [W-1:0] w_ramp_cur, w_ramp_nxt, w_word;
  logic [1:0]   w_idx_cur, w_idx_nxt;
  logic         w_phase_cur, w_phase_nxt, w_done_cur, w_done_nxt;
  logic [8:0]   w_pn9_cur, w_pn9_adv, w_pn9_nxt;
  logic [22:0]  w_pn23_cur, w_pn23_adv, w_pn23_nxt;
  logic [W-1:0] w_pn9_word, w_pn23_word;

  assign w_mode        = mode_e'(r_mode_sync[3:0]);
  assign w_seq         = seq_e'(r_mode_sync[7:6]);
  assign w_mode_change = (r_mode_sync[3:0] != r_mode_prev);
  assign w_seq_change  = (r_mode_sync[7:6] != r_seq_prev);
  assign w_pn9_hold    = r_mode_sync[4];
  assign w_pn23_hold   = r_mode_sync[5];

  // A mode change clears sequencing state in the same clk, so a coincident
  // sample already sees the cleared values.
  assign w_ramp_cur  = w_mode_change ? '0 : r_ramp;
  assign w_phase_cur = w_mode_change ? 1'b0 : r_phase;
  assign w_done_cur  = w_mode_change ? 1'b0 : r_single_done;
  assign w_idx_cur   = (w_mode_change || w_seq_change) ? 2'd0 : r_uidx;
  assign w_pn9_cur   = (w_mode_change || w_pn9_hold) ? PN_SEED9 : r_pn9;
  assign w_pn23_cur  = (w_mode_change || w_pn23_hold) ? PN_SEED23 : r_pn23;

  // Run both LFSRs W steps ahead; each generated bit lands MSB first.
  always_comb begin
    // NOTE: blocking assignments here build combinational values; every
    // output gets a default first so no latch is inferred.
    w_pn9_adv   = w_pn9_cur;
    w_pn23_adv  = w_pn23_cur;
    w_pn9_word  = '0;
    w_pn23_word = '0;
    for (int i = 0; i < W; i++) begin
      w_pn9_adv  = {w_pn9_adv[7:0], w_pn9_adv[8] ^ w_pn9_adv[4]};
      w_pn23_adv = {w_pn23_adv[21:0], w_pn23_adv[22] ^ w_pn23_adv[17]};
      w_pn9_word[W-1-i]  = w_pn9_adv[0];
      w_pn23_word[W-1-i] = w_pn23_adv[0];
    end
  end

  assign w_pn9_nxt  = (bus.sample_en && (w_mode == MODE_PN9) && !w_pn9_hold) ? w_pn9_adv : w_pn9_cur;
  assign w_pn23_nxt = (bus.sample_en && (w_mode == MODE_PN23) && !w_pn23_hold) ? w_pn23_adv : w_pn23_cur;

  // Select the output word and the next sequencing state for this mode.
  always_comb begin
    w_word      = '0;
    w_ramp_nxt  = w_ramp_cur;
    w_phase_nxt = w_phase_cur;
    w_idx_nxt   = w_idx_cur;
    w_done_nxt  = w_done_cur;
    case (w_mode)
      MODE_NORMAL:   w_word = bus.adc_data;
      MODE_MIDSCALE: w_word = MIDSCALE;
      MODE_POS_FS:   w_word = '1;
      MODE_NEG_FS:   w_word = '0;
      MODE_CHECKER: begin
        w_word      = w_phase_cur ? ~CHECKER_A : CHECKER_A;
        w_phase_nxt = ~w_phase_cur;
      end
      MODE_PN23:     w_word = w_pn23_word;
      MODE_PN9:      w_word = w_pn9_word;
      MODE_TOGGLE: begin
        w_word      = w_phase_cur ? '0 : '1;
        w_phase_nxt = ~w_phase_cur;
      end
      MODE_USER: begin
        case (w_seq)
          SEQ_REPEAT1: w_word = r_upat[0];
          SEQ_CYCLE4: begin
            w_word    = r_upat[w_idx_cur];
            w_idx_nxt = w_idx_cur + 2'd1;
          end
          SEQ_SINGLE: begin
            if (!w_done_cur) begin
              w_word     = r_upat[w_idx_cur];
              w_idx_nxt  = w_idx_cur + 2'd1;
              w_done_nxt = (w_idx_cur == 2'd3);
            end
          end
          SEQ_ALT12: begin
            w_word    = r_upat[{1'b0, w_idx_cur[0]}];
            w_idx_nxt = {1'b0, ~w_idx_cur[0]};
          end
        endcase
      end
      MODE_RAMP: begin
        w_word     = w_ramp_cur;
        w_ramp_nxt = w_ramp_cur + W'(1);
      end
      default:       w_word = '0;
    endcase
  end

  // Bring register fields into the sample domain: 2-flop sync for the mode,
  // a single capture stage for the quasi-static user words.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode_meta <= '0;
      r_mode_sync <= '0;
      r_mode_prev <= '0;
      r_seq_prev  <= '0;
      for (int i = 0; i < 4; i++) r_upat[i] <= '0;
    end else begin
      r_mode_meta <= bus.test_mode;
      r_mode_sync <= r_mode_meta;
      r_mode_prev <= r_mode_sync[3:0];
      r_seq_prev  <= r_mode_sync[7:6];
      r_upat[0]   <= bus.UserTestPattern1[15 -: W];
      r_upat[1]   <= bus.UserTestPattern2[15 -: W];
      r_upat[2]   <= bus.UserTestPattern3[15 -: W];
      r_upat[3]   <= bus.UserTestPattern4[15 -: W];
    end
  end

  // Generator state: cleared/reloaded values always land, advance only on sample_en.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ramp        <= '0;
      r_uidx        <= '0;
      r_phase       <= 1'b0;
      r_single_done <= 1'b0;
      r_pn9         <= PN_SEED9;
      r_pn23        <= PN_SEED23;
    end else begin
      r_ramp        <= bus.sample_en ? w_ramp_nxt  : w_ramp_cur;
      r_uidx        <= bus.sample_en ? w_idx_nxt   : w_idx_cur;
      r_phase       <= bus.sample_en ? w_phase_nxt : w_phase_cur;
      r_single_done <= bus.sample_en ? w_done_nxt  : w_done_cur;
      r_pn9         <= w_pn9_nxt;
      r_pn23        <= w_pn23_nxt;
    end
  end

  // Output register: word updates on a strobe and holds otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= bus.sample_en;
      if (bus.sample_en) r_data_out <= w_word;
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_valid     = r_data_valid;
  assign bus.pattern_active = (r_mode_sync[3:0] != 4'h0);
endmodule

// File: tb/tb_adc_test_pattern_gen.sv
// Directed bench for adc_test_pattern_gen: reset, normal and fixed modes,
// ramp wrap, checkerboard, PN9 with hold, user sequencing, async reset.
module tb_adc_test_pattern_gen;
  localparam int W = 14;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic pn_bits [$];
  logic [15:0] pn_w [3];

  adc_test_pattern_gen_if #(.DATA_WIDTH(W)) bus ();
  adc_test_pattern_gen #(.DATA_WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-clk strobe; the word is read on the following falling edge.
  task automatic samp(input string tag, input logic [15:0] exp);
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    check(tag, {2'b00, bus.data_out}, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic [7:0] m);
    bus.test_mode = m;
    idle(3);
  endtask

  // Reference PN9 as a bit recurrence x[k] = x[k-9] ^ x[k-5] from the seed.
  task automatic pn9_init();
    logic [8:0] seed;
    seed = 9'h1FF;
    pn_bits.delete();
    for (int i = 8; i >= 0; i--) pn_bits.push_back(seed[i]);
  endtask

  task automatic pn9_word(output logic [15:0] w);
    int   n;
    logic b;
    w = '0;
    for (int i = 0; i < W; i++) begin
      n = pn_bits.size();
      b = pn_bits[n-9] ^ pn_bits[n-5];
      pn_bits.push_back(b);
      w[W-1-i] = b;
    end
  endtask

  initial begin
    resetn               = 1'b0;
    bus.sample_en        = 1'b0;
    bus.adc_data         = '0;
    bus.test_mode        = 8'h00;
    bus.UserTestPattern1 = 16'h1111;
    bus.UserTestPattern2 = 16'h2222;
    bus.UserTestPattern3 = 16'h3333;
    bus.UserTestPattern4 = 16'h4444;
    idle(3);
    check("rst_data_out", {2'b00, bus.data_out}, 16'h0000);
    check("rst_data_valid", {15'd0, bus.data_valid}, 16'h0000);
    check("rst_pattern_active", {15'd0, bus.pattern_active}, 16'h0000);
    resetn = 1'b1;
    idle(2);

    // Normal mode, valid pulse and hold.
    bus.adc_data = 14'h1234;
    samp("normal_1234", 16'h1234);
    check("valid_high", {15'd0, bus.data_valid}, 16'h0001);
    bus.adc_data = 14'h0BAD;
    @(negedge clk);
    check("valid_low", {15'd0, bus.data_valid}, 16'h0000);
    check("data_hold", {2'b00, bus.data_out}, 16'h1234);
    samp("normal_0bad", 16'h0BAD);

    // Fixed levels and toggle.
    set_mode(8'h01);
    check("pattern_active", {15'd0, bus.pattern_active}, 16'h0001);
    samp("midscale", 16'h2000);
    set_mode(8'h02);
    samp("pos_fs", 16'h3FFF);
    set_mode(8'h03);
    samp("neg_fs", 16'h0000);
    set_mode(8'h07);
    samp("toggle_0", 16'h3FFF);
    samp("toggle_1", 16'h0000);
    samp("toggle_2", 16'h3FFF);
    set_mode(8'h0A);
    samp("undefined_mode", 16'h0000);

    // Ramp through the wrap, then checkerboard mid-ramp.
    set_mode(8'h0F);
    for (int i = 0; i < 16390; i++) samp("ramp", 16'(i % 16384));
    samp("ramp_after_wrap", 16'h0006);
    set_mode(8'h04);
    samp("checker_0", 16'h2AAA);
    samp("checker_1", 16'h1555);
    samp("checker_2", 16'h2AAA);

    // PN9 from seed, hold, release.
    pn9_init();
    for (int i = 0; i < 3; i++) pn9_word(pn_w[i]);
    set_mode(8'h06);
    samp("pn9_w0", pn_w[0]);
    samp("pn9_w1", pn_w[1]);
    samp("pn9_w2", pn_w[2]);
    set_mode(8'h16);
    samp("pn9_hold_a", pn_w[0]);
    samp("pn9_hold_b", pn_w[0]);
    set_mode(8'h06);
    samp("pn9_resume_w0", pn_w[0]);
    samp("pn9_resume_w1", pn_w[1]);

    // User sequencing.
    set_mode(8'h48);
    for (int r = 0; r < 2; r++) begin
      samp("user_cycle_1", 16'h0444);
      samp("user_cycle_2", 16'h0888);
      samp("user_cycle_3", 16'h0CCC);
      samp("user_cycle_4", 16'h1111);
    end
    set_mode(8'h08);
    samp("user_repeat_a", 16'h0444);
    samp("user_repeat_b", 16'h0444);
    set_mode(8'hC8);
    samp("user_alt_1", 16'h0444);
    samp("user_alt_2", 16'h0888);
    samp("user_alt_3", 16'h0444);
    samp("user_alt_4", 16'h0888);
    set_mode(8'h88);
    samp("user_single_1", 16'h0444);
    samp("user_single_2", 16'h0888);
    samp("user_single_3", 16'h0CCC);
    samp("user_single_4", 16'h1111);
    samp("user_single_done_a", 16'h0000);
    samp("user_single_done_b", 16'h0000);

    // Asynchronous reset in the middle of a user cycle.
    set_mode(8'h48);
    samp("user_pre_rst_1", 16'h0444);
    samp("user_pre_rst_2", 16'h0888);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_data_out", {2'b00, bus.data_out}, 16'h0000);
    check("async_rst_valid", {15'd0, bus.data_valid}, 16'h0000);
    check("async_rst_active", {15'd0, bus.pattern_active}, 16'h0000);
    @(negedge clk);
    resetn = 1'b1;
    idle(3);
    check("post_rst_active", {15'd0, bus.pattern_active}, 16'h0001);
    samp("post_rst_user_1", 16'h0444);
    samp("post_rst_user_2", 16'h0888);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
